// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file write port, with per-side FIFOs,
// round-robin arbitration that preserves same-register write order, and a pending-write query.
// Optional macro WB_FWD_EN adds rq_data, the youngest pending value for rq_reg.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int SEQ_W  = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
`ifdef WB_FWD_EN
    output logic [DATA_W-1:0] rq_data,
`endif
    input  logic [ADDR_W-1:0] rq_reg,
    output logic              rq_pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [ADDR_W-1:0] a_rmem_q [DEPTH];
    logic [DATA_W-1:0] a_dmem_q [DEPTH];
    logic [SEQ_W-1:0]  a_smem_q [DEPTH];
    logic [ADDR_W-1:0] b_rmem_q [DEPTH];
    logic [DATA_W-1:0] b_dmem_q [DEPTH];
    logic [SEQ_W-1:0]  b_smem_q [DEPTH];

    logic [PW-1:0]     a_wp_q, a_wp_d, a_rp_q, a_rp_d;
    logic [PW-1:0]     b_wp_q, b_wp_d, b_rp_q, b_rp_d;
    logic [CW-1:0]     a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [SEQ_W-1:0]  seq_q, seq_d, a_seq_new, b_seq_new;
    logic              favor_a_q, favor_a_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              a_push, b_push, a_pop, b_pop, a_ne, b_ne;
    logic [ADDR_W-1:0] a_hreg, b_hreg;
    logic [DATA_W-1:0] a_hdata, b_hdata;
    logic [SEQ_W-1:0]  a_hseq, b_hseq;
    logic [DEPTH-1:0]  a_live, b_live;
    logic              rq_hit;

    // x is older than y when y - x, taken modulo 2^SEQ_W, is a small positive distance.
    function automatic logic seq_older(input logic [SEQ_W-1:0] x, input logic [SEQ_W-1:0] y);
        logic [SEQ_W-1:0] diff;
        diff = y - x;
        return !diff[SEQ_W-1];
    endfunction

    function automatic logic slot_live(input logic [PW-1:0] idx, input logic [PW-1:0] rp,
                                       input logic [CW-1:0] cnt);
        logic [PW-1:0] off;
        off = idx - rp;
        return {1'b0, off} < cnt;
    endfunction

    always_comb begin
        a_ready   = res && (a_cnt_q < FULL_C);
        b_ready   = res && (b_cnt_q < FULL_C);
        a_push    = a_valid && a_ready && (a_reg != '0);
        b_push    = b_valid && b_ready && (b_reg != '0);
        a_ne      = (a_cnt_q != '0);
        b_ne      = (b_cnt_q != '0);
        a_hreg    = a_rmem_q[a_rp_q];
        a_hdata   = a_dmem_q[a_rp_q];
        a_hseq    = a_smem_q[a_rp_q];
        b_hreg    = b_rmem_q[b_rp_q];
        b_hdata   = b_dmem_q[b_rp_q];
        b_hseq    = b_smem_q[b_rp_q];
        a_seq_new = seq_q;
        b_seq_new = seq_q + SEQ_W'(a_push);
        seq_d     = b_seq_new + SEQ_W'(b_push);
    end

    // Same-register heads go strictly by age; otherwise alternate with the last grant.
    always_comb begin
        a_pop = 1'b0;
        b_pop = 1'b0;
        if (a_ne && !b_ne) begin
            a_pop = 1'b1;
        end else if (b_ne && !a_ne) begin
            b_pop = 1'b1;
        end else if (a_ne && b_ne) begin
            if (a_hreg == b_hreg) begin
                if (seq_older(a_hseq, b_hseq)) a_pop = 1'b1;
                else                           b_pop = 1'b1;
            end else if (favor_a_q) begin
                a_pop = 1'b1;
            end else begin
                b_pop = 1'b1;
            end
        end
    end

    always_comb begin
        a_wp_d    = a_wp_q + PW'(a_push);
        a_rp_d    = a_rp_q + PW'(a_pop);
        a_cnt_d   = a_cnt_q + CW'(a_push) - CW'(a_pop);
        b_wp_d    = b_wp_q + PW'(b_push);
        b_rp_d    = b_rp_q + PW'(b_pop);
        b_cnt_d   = b_cnt_q + CW'(b_push) - CW'(b_pop);
        favor_a_d = a_pop ? 1'b0 : (b_pop ? 1'b1 : favor_a_q);
        wr_en_d   = a_pop || b_pop;
        wr_reg_d  = a_pop ? a_hreg  : (b_pop ? b_hreg  : wr_reg_q);
        wr_data_d = a_pop ? a_hdata : (b_pop ? b_hdata : wr_data_q);
    end

    always_ff @(posedge clk) begin
        if (a_push) begin
            a_rmem_q[a_wp_q] <= a_reg;
            a_dmem_q[a_wp_q] <= a_data;
            a_smem_q[a_wp_q] <= a_seq_new;
        end
        if (b_push) begin
            b_rmem_q[b_wp_q] <= b_reg;
            b_dmem_q[b_wp_q] <= b_data;
            b_smem_q[b_wp_q] <= b_seq_new;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            a_wp_q    <= '0;
            a_rp_q    <= '0;
            a_cnt_q   <= '0;
            b_wp_q    <= '0;
            b_rp_q    <= '0;
            b_cnt_q   <= '0;
            seq_q     <= '0;
            favor_a_q <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            a_wp_q    <= a_wp_d;
            a_rp_q    <= a_rp_d;
            a_cnt_q   <= a_cnt_d;
            b_wp_q    <= b_wp_d;
            b_rp_q    <= b_rp_d;
            b_cnt_q   <= b_cnt_d;
            seq_q     <= seq_d;
            favor_a_q <= favor_a_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;

    always_comb begin
        a_live = '0;
        b_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            a_live[i] = slot_live(PW'(i), a_rp_q, a_cnt_q);
            b_live[i] = slot_live(PW'(i), b_rp_q, b_cnt_q);
        end
    end

    always_comb begin
        rq_hit = wr_en_q && (wr_reg_q == rq_reg);
        for (int i = 0; i < DEPTH; i++) begin
            if (a_live[i] && (a_rmem_q[i] == rq_reg)) rq_hit = 1'b1;
            if (b_live[i] && (b_rmem_q[i] == rq_reg)) rq_hit = 1'b1;
        end
        rq_pending = (rq_reg != '0) && rq_hit;
    end

`ifdef WB_FWD_EN
    logic              fwd_found;
    logic [SEQ_W-1:0]  fwd_dist, fwd_tmp;
    logic [DATA_W-1:0] fwd_val;

    // Youngest entry has the smallest distance back from the next sequence number.
    always_comb begin
        fwd_found = 1'b0;
        fwd_dist  = '0;
        fwd_tmp   = '0;
        fwd_val   = '0;
        if (wr_en_q && (wr_reg_q == rq_reg)) fwd_val = wr_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_live[i] && (a_rmem_q[i] == rq_reg)) begin
                fwd_tmp = seq_q - a_smem_q[i];
                if (!fwd_found || (fwd_tmp < fwd_dist)) begin
                    fwd_found = 1'b1;
                    fwd_dist  = fwd_tmp;
                    fwd_val   = a_dmem_q[i];
                end
            end
            if (b_live[i] && (b_rmem_q[i] == rq_reg)) begin
                fwd_tmp = seq_q - b_smem_q[i];
                if (!fwd_found || (fwd_tmp < fwd_dist)) begin
                    fwd_found = 1'b1;
                    fwd_dist  = fwd_tmp;
                    fwd_val   = b_dmem_q[i];
                end
            end
        end
        rq_data = rq_pending ? fwd_val : '0;
    end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback requesters: A (ALU pipe) and B (load unit).
- Each requester has its own small FIFO.
- Arbitration is round-robin, except that write-after-write order to the same register is preserved.
- At most one register write is issued per cycle.
- A pending-write query port lets the hazard unit stall readers of registers that still have queued writes.

Parameters:
DATA_W, 32, data width of each write.
ADDR_W, 5, register index width.
DEPTH, 2, entries per requester FIFO; power of 2, minimum 2.
SEQ_W, 4, width of the age sequence counter; 2^SEQ_W must be > 2*DEPTH+1.

Ports:
clk  in  1  clock; all state updates on rising edge.
res  in  1  asynchronous, active-low reset.
a_valid  in  1  requester A write request.
a_ready  out  1  A FIFO can accept.
a_reg  in  ADDR_W  A destination register.
a_data  in  DATA_W  A write data.
b_valid  in  1  requester B write request.
b_ready  out  1  B FIFO can accept.
b_reg  in  ADDR_W  B destination register.
b_data  in  DATA_W  B write data.
wr_en  out  1  register file write enable (registered).
wr_reg  out  ADDR_W  register file write index (registered).
wr_data  out  DATA_W  register file write data (registered).
rq_reg  in  ADDR_W  hazard query register index.
rq_pending  out  1  a queued or in-flight write targets rq_reg (combinational).
rq_data  out  DATA_W  youngest pending value for rq_reg; present only with WB_FWD_EN.

Behaviour:
- Reset (res=0, asynchronous):
  - FIFOs emptied; queued writes discarded.
  - wr_en=0, wr_reg=0, wr_data=0.
  - a_ready=b_ready=0 while res=0.
  - Sequence counter=0; round-robin pointer favours A.
  - A reset asserted mid-operation drops all pending writes; nothing partial is issued.
- Handshake:
  - x_ready = !res_asserted && (FIFO count < DEPTH).
  - Transfer occurs when x_valid && x_ready at a rising edge.
  - a_ready and b_ready do not depend on a_valid or b_valid.
  - A FIFO that is full and popped in the same cycle still shows ready=0 (no same-cycle pass-through).
- Register 0: a request with x_reg==0 is accepted (handshake completes) but not enqueued. It never produces wr_en.
- Age tagging:
  - Each enqueued entry stores seq, the counter value at acceptance.
  - The counter increments by 1 per enqueued entry, modulo 2^SEQ_W.
  - If A and B enqueue on the same edge, A gets seq and B gets seq+1; the counter advances by 2.
  - "Older" is decided by the modular difference of seq values.
- Arbitration, evaluated on FIFO heads each cycle:
  - Only one FIFO non-empty: pop that head.
  - Both non-empty and heads target the same register: pop the older head.
  - Both non-empty, different registers: pop the side opposite the last grant. The pointer updates only on an actual pop.
- Issue:
  - The popped entry is registered into wr_en/wr_reg/wr_data.
  - wr_en=1 for exactly one cycle per entry; wr_en=0 when nothing is popped.
  - Latency: accepted at edge k, earliest wr_en high in the cycle after edge k+1.
  - Peak throughput: 1 write per cycle.
- Query:
  - rq_pending=1 if rq_reg!=0 and any valid FIFO entry, or the current wr_en stage, has that register index.
  - rq_reg==0 always gives rq_pending=0.
- Ordering guarantee: writes from the same requester are issued in acceptance order. Writes to the same register from different requesters are issued in global acceptance order.

Optional Feature:
Macro WB_FWD_EN.
- Defined: rq_data port exists and gives the data of the youngest pending write to rq_reg.
  - Priority: youngest by seq among FIFO entries, and the wr_en stage is treated as oldest.
  - rq_data=0 when rq_pending=0.
- Undefined: rq_data port and its compare/select logic are absent. rq_pending behaviour is unchanged.

Test Plan:
- Reset then idle:
  - a_ready=b_ready=0 during res=0 and 1 after release.
  - wr_en stays 0 for 10 cycles.
- Single write: A writes reg 5 = 0xDEADBEEF at edge k -> wr_en=1, wr_reg=5, wr_data=0xDEADBEEF in the cycle after edge k+1 only.
- Contention: A and B both continuously write distinct registers (A: 1,2,3; B: 10,11,12) -> issue order 1,10,2,11,3,12 with one write per cycle.
- WAW order:
  - B enqueues reg 7 = 0x22 one cycle before A enqueues reg 7 = 0x11; pointer favours A.
  - -> 0x22 is written before 0x11.
  - With WB_FWD_EN, rq_reg=7 returns 0x11 while both are pending.
- Full/backpressure and register 0:
  - Hold wr issue busy by keeping both FIFOs loaded; A FIFO reaches DEPTH -> a_ready=0 until a pop.
  - A write to reg 0 completes its handshake but never produces wr_en, and rq_pending(0)=0.
- Reset mid-stream: assert res with 3 entries queued -> wr_en=0 immediately, no queued write ever issues after release.
